// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard/forward bundle between the decode stage and the hazard unit.
// master drives the ID instruction; slave returns stall and operand selects.
interface hazard_forward_unit_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [4:0]  id_dst;
  logic        id_regwrite;
  logic        id_load;
  logic        stall;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic [15:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output id_dst, id_regwrite, id_load,
    input  stall, forward_a, forward_b, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_dst, id_regwrite, id_load,
    output stall, forward_a, forward_b, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall detection and EX operand forwarding for a 5-stage pipe.
// Tracks shadow EX/MEM/WB records of the instructions past ID.
module hazard_forward_unit (
  input logic             clk,
  input logic             reset,
  hazard_forward_unit_if.slave hif
);

  typedef struct packed {
    logic [4:0] dst;
    logic       regwrite;
    logic       load;
  } wr_t;

  typedef struct packed {
    wr_t        w;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } ex_t;

  ex_t         ex_q;
  ex_t         ex_d;
  wr_t         mem_q;
  wr_t         wb_q;
  logic [15:0] cnt_q;
  logic        stall;
  logic        hit_rs;
  logic        hit_rt;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;

  // Register 0 is hard-wired, so it never counts as written.
  function automatic logic writes(
    input wr_t        s,
    input logic [4:0] r
  );
    return s.regwrite && (s.dst == r) && (r != 5'd0);
  endfunction

  // MEM outranks WB; a load in MEM is never a source.
  function automatic logic [1:0] sel(
    input logic       use_r,
    input logic [4:0] r,
    input wr_t        m,
    input wr_t        b
  );
    logic [1:0] s;
    s = 2'b00;
    if (use_r && writes(m, r) && !m.load)
      s = 2'b10;
    else if (use_r && writes(b, r))
      s = 2'b01;
    return s;
  endfunction

  always_comb begin
    hit_rs = hif.id_use_rs && writes(ex_q.w, hif.id_rs);
    hit_rt = hif.id_use_rt && writes(ex_q.w, hif.id_rt);
    stall  = ex_q.w.load && (hit_rs || hit_rt);
  end

  always_comb begin
    fwd_a = sel(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    fwd_b = sel(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  end

  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.w.dst      = hif.id_dst;
      ex_d.w.regwrite = hif.id_regwrite;
      ex_d.w.load     = hif.id_load;
      ex_d.rs         = hif.id_rs;
      ex_d.rt         = hif.id_rt;
      ex_d.use_rs     = hif.id_use_rs;
      ex_d.use_rt     = hif.id_use_rt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q.w;
      ex_q  <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (stall && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign hif.stall       = stall;
  assign hif.forward_a   = fwd_a;
  assign hif.forward_b   = fwd_b;
  assign hif.stall_count = cnt_q;

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 SHALL have port: id_rs  input  5  rs field of the instruction in ID.
REQ-004 SHALL have port: id_rt  input  5  rt field of the instruction in ID.
REQ-005 SHALL have port: id_use_rs / id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have port: id_dst  input  5  destination register of the ID instruction.
REQ-007 SHALL have port: id_regwrite  input  1  ID instruction writes id_dst.
REQ-008 SHALL have port: id_load  input  1  ID instruction is a load (result available only in WB).
REQ-009 SHALL have port: stall  output  1  hold PC and IF/ID, insert a bubble into EX.
REQ-010 SHALL have port: forward_a / forward_b  output  2 each  EX operand select: 00 register-file data, 01 WB write data, 10 MEM ALU result.
REQ-011 SHALL have port: stall_count  output  16  count of stall cycles since reset.

Function
REQ-012 SHALL keep three internal stage records, EX, MEM and WB; each record holds dst[4:0], regwrite and load, and the EX record also holds rs, rt, use_rs and use_rt.
REQ-013 SHALL, on each rising edge, shift WB<=MEM and MEM<=EX unconditionally.
REQ-014 SHALL load EX from the id_* inputs on an edge where stall=0.
REQ-015 SHALL load EX as a bubble (regwrite=0, load=0, use_rs=0, use_rt=0) on an edge where stall=1.
REQ-016 SHALL treat a stage as a writer of register r only when its regwrite=1, its dst=r and r!=0; register 0 is never a hazard or forwarding source.
REQ-017 SHALL compute stall combinationally: 1 iff the EX record is a load writer of r and ((id_use_rs and id_rs=r) or (id_use_rt and id_rt=r)).
REQ-018 SHALL make a load-use hazard cost exactly one stall cycle; on the next cycle the load is in MEM, stall deasserts, and the dependent reaches EX while the load is in WB.
REQ-019 SHALL drive forward_a combinationally: 10 if EX.use_rs and MEM is a non-load writer of EX.rs; else 01 if EX.use_rs and WB is a writer of EX.rs; else 00.
REQ-020 SHALL drive forward_b by the same rule as forward_a, using EX.rt and EX.use_rt.
REQ-021 SHALL give MEM priority over WB when both write the same register (youngest value wins).
REQ-022 SHALL never drive code 11 on forward_a or forward_b.
REQ-023 SHALL not allow a load in MEM to match under REQ-019/020; REQ-017/018 guarantee this case cannot reach EX.
REQ-024 SHALL increment stall_count by 1 on each edge where stall=1, saturating at 16'hFFFF with no wrap.
REQ-025 SHALL have no stage latency on stall, forward_a or forward_b; they are pure functions of current state and inputs.

Reset
REQ-026 SHALL, while reset=0, clear all three stage records to bubbles (all fields 0) and clear stall_count to 0, asynchronously.
REQ-027 SHALL, with all records bubbles, yield stall=0, forward_a=00 and forward_b=00.
REQ-028 SHALL, when reset asserts during a stall, drop stall in the same cycle; no stale hazard survives reset.
REQ-029 SHALL sample the first id_* inputs into EX on the first rising edge after reset deasserts.

Verification
REQ-030 SHALL pass: ADD $3 then SUB using $3 as rs -> in the SUB's EX cycle forward_a=10, stall=0.
REQ-031 SHALL pass: ADD $3, an unrelated NOP, then OR reading $3 as rt -> forward_b=01 in the OR's EX cycle.
REQ-032 SHALL pass: LW $5 then ADD reading $5 as rs -> stall=1 for exactly one cycle, stall_count 0->1, then forward_a=01 in the ADD's EX cycle.
REQ-033 SHALL pass: ADD $4, ADD $4, then SUB reading $4 -> forward_a=10 (MEM priority), never 01.
REQ-034 SHALL pass: ADDI $0 then ADD reading $0 -> forward_a=00, stall=0; LW $0 followed by a $0 reader -> no stall.
REQ-035 SHALL pass: reset driven low mid-stall (LW $7 in EX, dependent in ID) -> stall=0, stall_count=0 and forward codes 00 immediately, without waiting for a clock edge.
